// File: rtl/key_load_ctrl.sv
// Serial key-loading controller for the locked c432: shifts key bits in over valid/ready and commits them atomically to the key lines.
// Optional parity check and failure lockout are enabled by defining KEY_LOAD_PARITY_EN.
module key_load_ctrl #(
    parameter int KEY_W    = 17,
    parameter int MAX_FAIL = 3,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_active,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       fail_cnt,
    output logic             lockout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_COMMIT,
        S_LOCKOUT
`ifdef KEY_LOAD_PARITY_EN
        , S_PAR
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             beat;
    logic             last_beat;
    logic             check_pass;
    logic             fail_now;

    // abort wins over a simultaneous transfer, so the beat is not consumed
    assign beat      = key_valid & key_ready & ~abort;
    assign last_beat = beat && (state == S_SHIFT) && (cnt == CNT_W'(KEY_W - 1));
    assign fail_now  = (state == S_CHECK) && !abort && !check_pass;

`ifdef KEY_LOAD_PARITY_EN
    logic par_bit;

    assign check_pass = (par_bit == ^shadow);
`else
    assign check_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (abort) state_nxt = S_IDLE;
`ifdef KEY_LOAD_PARITY_EN
                else if (last_beat) state_nxt = S_PAR;
`else
                else if (last_beat) state_nxt = S_CHECK;
`endif
            end
`ifdef KEY_LOAD_PARITY_EN
            S_PAR: begin
                if (abort)     state_nxt = S_IDLE;
                else if (beat) state_nxt = S_CHECK;
            end
`endif
            S_CHECK: begin
                if (abort)                             state_nxt = S_IDLE;
                else if (check_pass)                   state_nxt = S_COMMIT;
                else if (fail_cnt >= 4'(MAX_FAIL - 1)) state_nxt = S_LOCKOUT;
                else                                   state_nxt = S_IDLE;
            end
            S_COMMIT:  state_nxt = S_IDLE;
            S_LOCKOUT: state_nxt = S_LOCKOUT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        busy      = 1'b0;
        lockout   = 1'b0;
        case (state)
            S_SHIFT:   begin key_ready = 1'b1; busy = 1'b1; end
`ifdef KEY_LOAD_PARITY_EN
            S_PAR:     begin key_ready = 1'b1; busy = 1'b1; end
`endif
            S_CHECK:   busy = 1'b1;
            S_COMMIT:  busy = 1'b1;
            S_LOCKOUT: lockout = 1'b1;
            default:   ;
        endcase
    end

    // done and err are registered so they line up with the key_out / fail_cnt update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            cnt        <= '0;
            key_out    <= '0;
            key_active <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            fail_cnt   <= 4'd0;
`ifdef KEY_LOAD_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            done <= (state == S_COMMIT);
            err  <= fail_now;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shadow <= '0;
                        cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        shadow <= '0;
                        cnt    <= '0;
                    end else if (beat) begin
                        shadow <= {shadow[KEY_W-2:0], key_bit};
                        cnt    <= cnt + 1'b1;
                    end
                end
`ifdef KEY_LOAD_PARITY_EN
                S_PAR: begin
                    if (abort) begin
                        shadow <= '0;
                        cnt    <= '0;
                    end else if (beat) begin
                        par_bit <= key_bit;
                    end
                end
`endif
                S_CHECK: begin
                    if (abort || fail_now) begin
                        shadow <= '0;
                        cnt    <= '0;
                    end
                    if (fail_now && (fail_cnt < 4'(MAX_FAIL))) fail_cnt <= fail_cnt + 4'd1;
                end
                S_COMMIT: begin
                    key_out    <= shadow;
                    key_active <= 1'b1;
                    fail_cnt   <= 4'd0;
                end
                default: ;
            endcase
            // zeroize the live key on the way into lockout
            if ((state != S_LOCKOUT) && (state_nxt == S_LOCKOUT)) begin
                key_out    <= '0;
                key_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed self-checking bench for key_load_ctrl; parity/lockout steps run only when KEY_LOAD_PARITY_EN is defined.
module tb_key_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        key_bit;
    logic        key_valid;
    logic        key_ready;
    logic [16:0] key_out;
    logic        key_active;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  fail_cnt;
    logic        lockout;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [16:0] KEY_A = 17'h15A3C;
    localparam logic        PAR_A = 1'b1;
    localparam logic [16:0] KEY_B = 17'h0AAAA;
    localparam logic        PAR_B = 1'b0;

    key_load_ctrl #(.KEY_W(17), .MAX_FAIL(3), .CNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_active (key_active),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fail_cnt   (fail_cnt),
        .lockout    (lockout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // one clock step: drive inputs, pass the rising edge, settle 1 time unit
    task automatic applyStimulus(input logic s, input logic a, input logic b, input logic v);
        start     = s;
        abort     = a;
        key_bit   = b;
        key_valid = v;
        @(posedge clk);
        #1;
        start     = 1'b0;
        abort     = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_key_out"}, 32'(key_out), 32'h0);
        checkOutput({tag, "_key_active"}, 32'(key_active), 32'h0);
        checkOutput({tag, "_key_ready"}, 32'(key_ready), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkOutput({tag, "_fail_cnt"}, 32'(fail_cnt), 32'h0);
        checkOutput({tag, "_lockout"}, 32'(lockout), 32'h0);
    endtask

    // start pulse, 17 key beats MSB first, then the parity beat when enabled; returns just after the last accepted beat
    task automatic load_key(input logic [16:0] k, input logic p, input bit gaps);
        logic [16:0] kv;
        kv = k;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i >= 0; i--) begin
            if (gaps) applyStimulus(1'b0, 1'b0, ~kv[i], 1'b0);
            applyStimulus(1'b0, 1'b0, kv[i], 1'b1);
        end
`ifdef KEY_LOAD_PARITY_EN
        if (gaps) applyStimulus(1'b0, 1'b0, ~p, 1'b0);
        applyStimulus(1'b0, 1'b0, p, 1'b1);
`else
        if (p === 1'bx) $display("[TB] note: parity bit unused");
`endif
    endtask

    task automatic finish_good(input string tag, input logic [16:0] k, input logic [16:0] prev);
        checkOutput({tag, "_check_busy"}, 32'(busy), 32'h1);
        checkOutput({tag, "_check_ready"}, 32'(key_ready), 32'h0);
        checkOutput({tag, "_check_done"}, 32'(done), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_commit_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_commit_keyold"}, 32'(key_out), 32'(prev));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_done"}, 32'(done), 32'h1);
        checkOutput({tag, "_key_out"}, 32'(key_out), 32'(k));
        checkOutput({tag, "_key_active"}, 32'(key_active), 32'h1);
        checkOutput({tag, "_fail_cnt"}, 32'(fail_cnt), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkOutput({tag, "_busy_idle"}, 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'h0);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
        #12;
        check_reset_values("reset");
        do_reset();
        check_reset_values("post_reset");

        // good load of KEY_A
        load_key(KEY_A, PAR_A, 1'b0);
        finish_good("load_a", KEY_A, 17'h0);

`ifdef KEY_LOAD_PARITY_EN
        // bad parity keeps the previous key
        load_key(KEY_A, ~PAR_A, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bad1_err", 32'(err), 32'h1);
        checkOutput("bad1_done", 32'(done), 32'h0);
        checkOutput("bad1_fail_cnt", 32'(fail_cnt), 32'h1);
        checkOutput("bad1_key_out", 32'(key_out), 32'(KEY_A));
        checkOutput("bad1_key_active", 32'(key_active), 32'h1);
        checkOutput("bad1_lockout", 32'(lockout), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bad1_err_pulse", 32'(err), 32'h0);

        // three consecutive failures from reset lead to lockout
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            load_key(KEY_A, ~PAR_A, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("fail%0d_err", n), 32'(err), 32'h1);
            checkOutput($sformatf("fail%0d_cnt", n), 32'(fail_cnt), 32'(n));
            checkOutput($sformatf("fail%0d_lockout", n), 32'(lockout), (n == 3) ? 32'h1 : 32'h0);
        end
        checkOutput("lock_key_out", 32'(key_out), 32'h0);
        checkOutput("lock_key_active", 32'(key_active), 32'h0);
        checkOutput("lock_busy", 32'(busy), 32'h0);
        seen = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i >= 0; i--) begin
            seen = seen | key_ready | done;
            applyStimulus(1'b0, 1'b0, KEY_A[i], 1'b1);
        end
        applyStimulus(1'b0, 1'b0, PAR_A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            seen = seen | key_ready | done;
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("lock_no_ready_done", 32'(seen), 32'h0);
        checkOutput("lock_held", 32'(lockout), 32'h1);
        do_reset();
        check_reset_values("unlock");
`else
        // without parity a load can never fail
        checkOutput("nopar_err", 32'(err), 32'h0);
        do_reset();
`endif

        // abort after 8 beats, with a simultaneous valid beat
        load_key(KEY_A, PAR_A, 1'b0);
        finish_good("abort_pre", KEY_A, 17'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i >= 9; i--) applyStimulus(1'b0, 1'b0, KEY_B[i], 1'b1);
        checkOutput("abort_busy_before", 32'(busy), 32'h1);
        applyStimulus(1'b0, 1'b1, KEY_B[8], 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_ready", 32'(key_ready), 32'h0);
        checkOutput("abort_key_out", 32'(key_out), 32'(KEY_A));
        checkOutput("abort_key_active", 32'(key_active), 32'h1);
        checkOutput("abort_err", 32'(err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_err_late", 32'(err), 32'h0);
        checkOutput("abort_done_late", 32'(done), 32'h0);

        // key_valid toggling: only valid beats count
        load_key(KEY_B, PAR_B, 1'b1);
        finish_good("gaps", KEY_B, KEY_A);

        // asynchronous reset in the middle of SHIFT
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 16; i >= 12; i--) applyStimulus(1'b0, 1'b0, KEY_A[i], 1'b1);
        checkOutput("midrst_ready_before", 32'(key_ready), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst_release");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
